// File: rtl/dual_config_sequencer.sv
// -----------------------------------------------------------------------------
// dual_config_sequencer
//
// Turns simple commands into register accesses on a dual_config Avalon-MM
// slave: read the busy status, read the previous-state register, or reload
// the device from one of two images. A reload first polls the busy register
// until it clears, then writes config_sel and the trigger register.
//
// Parameters
//   READ_LATENCY  cycles from avmm_read to valid avmm_readdata (1..7)
//   POLL_LIMIT    busy polls allowed before a reload is abandoned (1..65535)
//
// Ports
//   clk             single rising-edge clock
//   reset           asynchronous, active-high reset
//   cmd_valid       command request, taken when cmd_ready is high
//   cmd_op[1:0]     0 = read busy, 1 = reconfigure, 2 = read previous-state,
//                   3 = reserved (answered with an error)
//   cmd_image       image selected by a reconfigure command
//   cmd_ready       high only while idle
//   rsp_valid       one-cycle response strobe
//   rsp_data[31:0]  read result (0 for reconfigure / reserved); held until
//                   the next response
//   rsp_error       timeout or reserved op, qualified by rsp_valid
//   avmm_*          master side of the Avalon-MM link to the dual_config slave
//
// Every output comes straight from a register: each transition loads the
// output values belonging to the state being entered.
// -----------------------------------------------------------------------------
module dual_config_sequencer #(
  parameter int READ_LATENCY = 2,
  parameter int POLL_LIMIT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_image,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [2:0]  avmm_address,
  output logic        avmm_read,
  output logic        avmm_write,
  output logic [31:0] avmm_writedata,
  input  logic [31:0] avmm_readdata
);

  // Register map of the dual_config slave
  localparam logic [2:0] ADDR_TRIGGER = 3'd0;
  localparam logic [2:0] ADDR_SEL     = 3'd1;
  localparam logic [2:0] ADDR_BUSY    = 3'd3;
  localparam logic [2:0] ADDR_PREV    = 3'd4;

  // Command opcodes
  localparam logic [1:0] OP_BUSY     = 2'd0;
  localparam logic [1:0] OP_RECONFIG = 2'd1;
  localparam logic [1:0] OP_PREV     = 2'd2;

  // Wait counter value on the last cycle of a read wait
  localparam logic [2:0]  LAT_LAST   = 3'(READ_LATENCY - 1);
  localparam logic [15:0] POLL_MAX   = 16'(POLL_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_SEL_WR,
    ST_TRIG_WR,
    ST_DATA_RD,
    ST_DATA_WAIT,
    ST_RESP
  } state_t;

  // config_sel write value: bit0 = overwrite, bit1 = image
  function automatic logic [31:0] f_sel_wdata(input logic image);
    f_sel_wdata = {30'd0, image, 1'b1};
  endfunction

  // Register read by a data command (op 0 or op 2)
  function automatic logic [2:0] f_data_addr(input logic [1:0] op);
    f_data_addr = (op == OP_PREV) ? ADDR_PREV : ADDR_BUSY;
  endfunction

  state_t      r_state;
  logic        r_image;
  logic [2:0]  r_wait_cnt;
  logic [15:0] r_poll_cnt;

  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_error;
  logic [2:0]  r_avmm_address;
  logic        r_avmm_read;
  logic        r_avmm_write;
  logic [31:0] r_avmm_writedata;

  logic        w_accept;
  logic        w_lat_done;
  logic        w_busy;
  logic [15:0] w_poll_cnt_nxt;
  logic        w_poll_exhausted;

  // r_cmd_ready is high exactly while r_state is IDLE
  assign w_accept         = cmd_valid & r_cmd_ready;
  assign w_lat_done       = (r_wait_cnt == LAT_LAST);
  assign w_busy           = avmm_readdata[0];
  assign w_poll_cnt_nxt   = r_poll_cnt + 16'd1;
  assign w_poll_exhausted = (w_poll_cnt_nxt == POLL_MAX);

  // Sequencer FSM with registered outputs for the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_image          <= 1'b0;
      r_wait_cnt       <= 3'd0;
      r_poll_cnt       <= 16'd0;
      r_cmd_ready      <= 1'b1;
      r_rsp_valid      <= 1'b0;
      r_rsp_data       <= 32'd0;
      r_rsp_error      <= 1'b0;
      r_avmm_address   <= 3'd0;
      r_avmm_read      <= 1'b0;
      r_avmm_write     <= 1'b0;
      r_avmm_writedata <= 32'd0;
    end else begin
      // Strobes last one cycle; bus returns to all-zero unless a state drives it
      r_cmd_ready      <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_avmm_address   <= 3'd0;
      r_avmm_read      <= 1'b0;
      r_avmm_write     <= 1'b0;
      r_avmm_writedata <= 32'd0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_image    <= cmd_image;
            r_poll_cnt <= 16'd0;
            r_wait_cnt <= 3'd0;
            case (cmd_op)
              OP_RECONFIG: begin
                r_state        <= ST_POLL_RD;
                r_avmm_read    <= 1'b1;
                r_avmm_address <= ADDR_BUSY;
              end
              OP_BUSY, OP_PREV: begin
                r_state        <= ST_DATA_RD;
                r_avmm_read    <= 1'b1;
                r_avmm_address <= f_data_addr(cmd_op);
              end
              default: begin
                // Reserved op: answer at once with an error, no bus access
                r_state     <= ST_RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= 32'd0;
                r_rsp_error <= 1'b1;
              end
            endcase
          end else begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
          end
        end

        ST_POLL_RD: begin
          r_state    <= ST_POLL_WAIT;
          r_wait_cnt <= 3'd0;
        end

        ST_POLL_WAIT: begin
          if (w_lat_done) begin
            r_poll_cnt <= w_poll_cnt_nxt;
            if (!w_busy) begin
              r_state          <= ST_SEL_WR;
              r_avmm_write     <= 1'b1;
              r_avmm_address   <= ADDR_SEL;
              r_avmm_writedata <= f_sel_wdata(r_image);
            end else if (w_poll_exhausted) begin
              // Still busy on the last allowed poll: give up without writing
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 32'd0;
              r_rsp_error <= 1'b1;
            end else begin
              r_state        <= ST_POLL_RD;
              r_avmm_read    <= 1'b1;
              r_avmm_address <= ADDR_BUSY;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end

        ST_SEL_WR: begin
          r_state          <= ST_TRIG_WR;
          r_avmm_write     <= 1'b1;
          r_avmm_address   <= ADDR_TRIGGER;
          r_avmm_writedata <= 32'h0000_0001;
        end

        ST_TRIG_WR: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= 32'd0;
          r_rsp_error <= 1'b0;
        end

        ST_DATA_RD: begin
          r_state    <= ST_DATA_WAIT;
          r_wait_cnt <= 3'd0;
        end

        ST_DATA_WAIT: begin
          if (w_lat_done) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= avmm_readdata;
            r_rsp_error <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end

        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_error      = r_rsp_error;
  assign avmm_address   = r_avmm_address;
  assign avmm_read      = r_avmm_read;
  assign avmm_write     = r_avmm_write;
  assign avmm_writedata = r_avmm_writedata;

endmodule

// File: tb/tb_dual_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dual_config_sequencer
//
// Directed bench for dual_config_sequencer (READ_LATENCY=2, POLL_LIMIT=4).
// A behavioural dual_config slave answers reads READ_LATENCY cycles after
// avmm_read and shows garbage otherwise; busy reads return 1 for a set
// number of polls and then 0. All bus traffic is logged for checking.
// -----------------------------------------------------------------------------
module tb_dual_config_sequencer;

  localparam int LAT   = 2;
  localparam int PLIM  = 4;
  localparam logic [31:0] GARB = 32'hBAD0_0BAD;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_image;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [2:0]  avmm_address;
  logic        avmm_read;
  logic        avmm_write;
  logic [31:0] avmm_writedata;
  logic [31:0] avmm_readdata = 32'hBAD0_0BAD;

  int total = 0;
  int bad   = 0;

  dual_config_sequencer #(.READ_LATENCY(LAT), .POLL_LIMIT(PLIM)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_image      (cmd_image),
    .cmd_ready      (cmd_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .avmm_address   (avmm_address),
    .avmm_read      (avmm_read),
    .avmm_write     (avmm_write),
    .avmm_writedata (avmm_writedata),
    .avmm_readdata  (avmm_readdata)
  );

  always #5 clk = ~clk;

  // Slave model and bus log
  int          n_rd = 0, n_wr = 0, n_rsp = 0, n_busy_rd = 0;
  int          busy_mark = 0, busy_polls = 0;
  logic [31:0] prev_state_val = 32'd0;
  logic [2:0]  rd_log [0:255];
  logic [2:0]  wr_addr_log [0:255];
  logic [31:0] wr_data_log [0:255];
  logic        bus_viol = 1'b0;
  logic        rd_pend = 1'b0;
  int          rd_dly = 0;
  logic [31:0] rd_val = 32'd0;

  always @(posedge clk) begin
    if (avmm_read) begin
      if (n_rd < 256) rd_log[n_rd] <= avmm_address;
      n_rd    <= n_rd + 1;
      rd_pend <= 1'b1;
      rd_dly  <= 1;
      avmm_readdata <= GARB;
      if (avmm_address == 3'd3) begin
        rd_val    <= {31'd0, ((n_busy_rd - busy_mark) < busy_polls)};
        n_busy_rd <= n_busy_rd + 1;
      end else if (avmm_address == 3'd4) begin
        rd_val <= prev_state_val;
      end else begin
        rd_val <= GARB;
      end
    end else if (rd_pend && rd_dly == LAT - 1) begin
      avmm_readdata <= rd_val;
      rd_pend       <= 1'b0;
    end else if (rd_pend) begin
      rd_dly        <= rd_dly + 1;
      avmm_readdata <= GARB;
    end else begin
      avmm_readdata <= GARB;
    end
    if (avmm_write) begin
      if (n_wr < 256) begin
        wr_addr_log[n_wr] <= avmm_address;
        wr_data_log[n_wr] <= avmm_writedata;
      end
      n_wr <= n_wr + 1;
    end
    if (rsp_valid) n_rsp <= n_rsp + 1;
    if (avmm_read && avmm_write) bus_viol <= 1'b1;
    if (!avmm_read && !avmm_write && (avmm_address != 3'd0 || avmm_writedata != 32'd0))
      bus_viol <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int rd_base, wr_base, rsp_base;

  // Waits for rsp_valid after the accept edge; lat=1 means seen one edge later
  task automatic wait_rsp(output int lat);
    lat = 999;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid) begin
        lat = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Issues one command, measures latency, leaves the DUT idle again
  task automatic run_cmd(input logic [1:0] op, input logic img, output int lat);
    rd_base  = n_rd;
    wr_base  = n_wr;
    rsp_base = n_rsp;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_image = img;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("rsp_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  int lat, rd_snap, wr_snap, rsp_snap;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_image = 1'b0;
    #2;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_bus", {avmm_read, avmm_write, avmm_address, avmm_writedata[26:0]}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // op 0, busy register reads 0
    busy_mark = n_busy_rd; busy_polls = 0;
    run_cmd(2'd0, 1'b0, lat);
    chk("op0_lat", 32'(lat), 32'd4);
    chk("op0_nrd", 32'(n_rd - rd_base), 32'd1);
    chk("op0_addr", 32'(rd_log[rd_base]), 32'd3);
    chk("op0_data", rsp_data, 32'd0);
    chk("op0_err", 32'(rsp_error), 32'd0);
    chk("op0_ready", 32'(cmd_ready), 32'd1);

    // op 1, image 1, busy for 3 polls: 4 polls, latency 4*3+3
    busy_mark = n_busy_rd; busy_polls = 3;
    run_cmd(2'd1, 1'b1, lat);
    chk("rc1_lat", 32'(lat), 32'd15);
    chk("rc1_nrd", 32'(n_rd - rd_base), 32'd4);
    chk("rc1_rd_addr_last", 32'(rd_log[rd_base + 3]), 32'd3);
    chk("rc1_nwr", 32'(n_wr - wr_base), 32'd2);
    chk("rc1_wr0_addr", 32'(wr_addr_log[wr_base]), 32'd1);
    chk("rc1_wr0_data", wr_data_log[wr_base], 32'h3);
    chk("rc1_wr1_addr", 32'(wr_addr_log[wr_base + 1]), 32'd0);
    chk("rc1_wr1_data", wr_data_log[wr_base + 1], 32'h1);
    chk("rc1_data", rsp_data, 32'd0);
    chk("rc1_err", 32'(rsp_error), 32'd0);

    // op 1, image 0, idle at once: single poll, latency 3+3
    busy_mark = n_busy_rd; busy_polls = 0;
    run_cmd(2'd1, 1'b0, lat);
    chk("rc0_lat", 32'(lat), 32'd6);
    chk("rc0_nrd", 32'(n_rd - rd_base), 32'd1);
    chk("rc0_wr0_data", wr_data_log[wr_base], 32'h1);
    chk("rc0_wr1_addr", 32'(wr_addr_log[wr_base + 1]), 32'd0);

    // op 1 with busy stuck: POLL_LIMIT polls, error, no write
    busy_mark = n_busy_rd; busy_polls = 100;
    run_cmd(2'd1, 1'b1, lat);
    chk("tmo_lat", 32'(lat), 32'd13);
    chk("tmo_nrd", 32'(n_rd - rd_base), 32'd4);
    chk("tmo_nwr", 32'(n_wr - wr_base), 32'd0);
    chk("tmo_err", 32'(rsp_error), 32'd1);
    chk("tmo_data", rsp_data, 32'd0);

    // op 3 reserved: immediate error, no bus access
    run_cmd(2'd3, 1'b0, lat);
    chk("op3_lat", 32'(lat), 32'd1);
    chk("op3_bus", 32'((n_rd - rd_base) + (n_wr - wr_base)), 32'd0);
    chk("op3_err", 32'(rsp_error), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("op3_err_hold", 32'(rsp_error), 32'd1);
    chk("op3_data_hold", rsp_data, 32'd0);

    // op 2 with cmd_valid held through the command (next op is 0)
    prev_state_val = 32'hA5;
    busy_mark = n_busy_rd; busy_polls = 5;
    rd_base = n_rd;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    @(posedge clk); #1;
    cmd_op = 2'd0;
    chk("hold_ready_low", 32'(cmd_ready), 32'd0);
    wait_rsp(lat);
    chk("op2_lat", 32'(lat), 32'd4);
    chk("op2_addr", 32'(rd_log[rd_base]), 32'd4);
    chk("op2_data", rsp_data, 32'hA5);
    chk("op2_err", 32'(rsp_error), 32'd0);
    chk("hold_nrd_busy", 32'(n_rd - rd_base), 32'd1);
    @(posedge clk); #1;
    chk("hold_ready_back", 32'(cmd_ready), 32'd1);
    chk("hold_nrd_idle", 32'(n_rd - rd_base), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("held_lat", 32'(lat), 32'd4);
    chk("held_addr", 32'(rd_log[rd_base + 1]), 32'd3);
    chk("held_data", rsp_data, 32'd1);
    @(posedge clk); #1;

    // reset while in POLL_WAIT aborts the reconfigure
    busy_mark = n_busy_rd; busy_polls = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_image = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_rsp_data", rsp_data, 32'd0);
    chk("arst_rsp", {rsp_valid, rsp_error}, 32'd0);
    chk("arst_bus", {avmm_read, avmm_write, avmm_address, avmm_writedata[26:0]}, 32'd0);
    rd_snap = n_rd; wr_snap = n_wr; rsp_snap = n_rsp;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("arst_no_write", 32'(n_wr - wr_snap), 32'd0);
    chk("arst_no_read", 32'(n_rd - rd_snap), 32'd0);
    chk("arst_no_rsp", 32'(n_rsp - rsp_snap), 32'd0);
    chk("arst_idle", 32'(cmd_ready), 32'd1);

    chk("bus_rules", 32'(bus_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
